// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready stream FIFO with occupancy, almost-full and optional high-water mark
// Optional feature macro: STREAM_FIFO_PEAK_EN (peak_level register; tied to 0 when undefined).
module stream_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    peak_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("stream_fifo: AFULL_THRESH must be in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  afull_q, afull_d;
    logic                  push, pop;

    assign s_ready     = (count_q != DEPTH_C);
    assign m_valid     = (count_q != '0);
    assign m_data      = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = afull_q;
    assign push        = s_valid & s_ready;
    assign pop         = m_valid & m_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = s_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
        // Registered from next-count so the flag lines up with the count it describes.
        afull_d = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

`ifdef STREAM_FIFO_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    // Follows the registered count, so it lags a new maximum by one cycle; flush does not clear it.
    always_comb begin
        peak_d = (count_q > peak_q) ? count_q : peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

`ifndef SYNTHESIS
    a_sdata_stable: assert property (@(posedge clk)
        (!rst && !flush && s_valid && !s_ready) |=> $stable(s_data));
    a_svalid_hold: assert property (@(posedge clk)
        (!rst && !flush && s_valid && !s_ready) |=> s_valid)
        else $warning("stream_fifo: s_valid dropped without a handshake");
    a_count_max: assert property (@(posedge clk) count_q <= DEPTH_C);
`endif
endmodule
